layer_scan_controller: RTL and testbench

//  Sequences per-frame reads of the 32-entry layer header store and forwards enabled layers to the render engine.

---
 rtl/layer_scan_controller.sv | 160 ++++++++++++++++
 tb/tb_layer_scan_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scan_controller.sv
// layer_scan_controller
//   Walks the layer header store once per frame, fetching each layer's
//   128-bit header and forwarding the enabled ones to the render engine as
//   descriptors. It also owns the store's write port. Host writes pass
//   straight through, except a write aimed at the layer currently being
//   fetched, which is held off until that header has been captured.
//
// Ports
//   clk, reset                  master clock, synchronous active-high reset
//   frame_start                 1-cycle pulse that starts a scan
//   host_wr_valid/ready         host write handshake
//   host_wr_layer/reg/data      host write target and data
//   hdr_read_layer              header store read address (scan index)
//   hdr_write_en/layer/reg/data header store write port
//   hdr_layer_info              header store read data (8 x 16-bit registers)
//   out_valid/ready             descriptor handshake to the engine
//   out_layer, out_info         captured descriptor
//   out_last                    descriptor is the final layer of the scan
//   scan_busy                   scan in progress
//   scan_done                   1-cycle pulse when a scan completes
//   frame_overrun               1-cycle pulse: frame_start arrived while busy

module layer_scan_controller #(
  parameter int NUM_LAYERS = 32,
  parameter int RD_LAT     = 1,
  parameter int EN_BIT     = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_start,
  input  logic         host_wr_valid,
  output logic         host_wr_ready,
  input  logic [4:0]   host_wr_layer,
  input  logic [2:0]   host_wr_reg,
  input  logic [15:0]  host_wr_data,
  output logic [4:0]   hdr_read_layer,
  output logic         hdr_write_en,
  output logic [4:0]   hdr_write_layer,
  output logic [2:0]   hdr_write_reg,
  output logic [15:0]  hdr_write_data,
  input  logic [127:0] hdr_layer_info,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [4:0]   out_layer,
  output logic [127:0] out_info,
  output logic         out_last,
  output logic         scan_busy,
  output logic         scan_done,
  output logic         frame_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    DONE
  } state_t;

  localparam logic [4:0] LAST_LAYER = 5'(NUM_LAYERS - 1);
  localparam logic [2:0] LAT        = 3'(RD_LAT);

  state_t       state, state_next;
  logic [4:0]   cur, cur_next;
  logic [2:0]   cnt, cnt_next;
  logic [127:0] info_q, info_next;
  logic [4:0]   layer_q, layer_next;
  logic         overrun_q;

  // State register and captured descriptor. The overrun flag is registered so
  // it pulses the cycle after the offending frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= '0;
      info_q    <= '0;
      layer_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_next;
      cur       <= cur_next;
      cnt       <= cnt_next;
      info_q    <= info_next;
      layer_q   <= layer_next;
      overrun_q <= frame_start && (state != IDLE);
    end
  end

  // Next-state logic. Advancing to the next layer is folded into the
  // transition out of WAIT (disabled layer) or EMIT (handshake), so it costs
  // no cycle of its own.
  always_comb begin
    state_next = state;
    cur_next   = cur;
    cnt_next   = cnt;
    info_next  = info_q;
    layer_next = layer_q;
    unique case (state)
      IDLE: begin
        if (frame_start) begin
          cur_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = LAT;
        state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt - 3'd1;
        if (cnt == 3'd1) begin
          info_next  = hdr_layer_info;
          layer_next = cur;
          if (hdr_layer_info[EN_BIT]) begin
            state_next = EMIT;
          end else if (cur == LAST_LAYER) begin
            state_next = DONE;
          end else begin
            cur_next   = cur + 5'd1;
            state_next = ISSUE;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (cur == LAST_LAYER) begin
            state_next = DONE;
          end else begin
            cur_next   = cur + 5'd1;
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        cur_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A write that targets the layer whose header is in flight would make the
  // captured header ambiguous, so it is stalled until capture has happened.
  assign host_wr_ready   = !(((state == ISSUE) || (state == WAIT)) && (host_wr_layer == cur));
  assign hdr_write_en    = host_wr_valid && host_wr_ready;
  assign hdr_write_layer = host_wr_layer;
  assign hdr_write_reg   = host_wr_reg;
  assign hdr_write_data  = host_wr_data;

  assign hdr_read_layer = cur;
  assign out_valid      = (state == EMIT);
  assign out_layer      = layer_q;
  assign out_info       = info_q;
  assign out_last       = out_valid && (layer_q == LAST_LAYER);
  assign scan_busy      = (state != IDLE);
  assign scan_done      = (state == DONE);
  assign frame_overrun  = overrun_q;

endmodule

// File: tb/tb_layer_scan_controller.sv
// tb_layer_scan_controller
//   Directed bench for layer_scan_controller. Contains a 32 x 8 x 16-bit header
//   store with a one-cycle registered read, driven by the DUT's read/write
//   ports. A shadow copy of what the host wrote provides expected headers.

module tb_layer_scan_controller;

  logic         clk;
  logic         reset;
  logic         frame_start;
  logic         host_wr_valid;
  logic         host_wr_ready;
  logic [4:0]   host_wr_layer;
  logic [2:0]   host_wr_reg;
  logic [15:0]  host_wr_data;
  logic [4:0]   hdr_read_layer;
  logic         hdr_write_en;
  logic [4:0]   hdr_write_layer;
  logic [2:0]   hdr_write_reg;
  logic [15:0]  hdr_write_data;
  logic [127:0] hdr_layer_info;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_layer;
  logic [127:0] out_info;
  logic         out_last;
  logic         scan_busy;
  logic         scan_done;
  logic         frame_overrun;

  logic         store_clear;
  logic [15:0]  store  [32][8];
  logic [15:0]  shadow [32][8];

  int compares   = 0;
  int mismatches = 0;

  layer_scan_controller #(
    .NUM_LAYERS(32),
    .RD_LAT    (1),
    .EN_BIT    (0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .host_wr_valid  (host_wr_valid),
    .host_wr_ready  (host_wr_ready),
    .host_wr_layer  (host_wr_layer),
    .host_wr_reg    (host_wr_reg),
    .host_wr_data   (host_wr_data),
    .hdr_read_layer (hdr_read_layer),
    .hdr_write_en   (hdr_write_en),
    .hdr_write_layer(hdr_write_layer),
    .hdr_write_reg  (hdr_write_reg),
    .hdr_write_data (hdr_write_data),
    .hdr_layer_info (hdr_layer_info),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_layer      (out_layer),
    .out_info       (out_info),
    .out_last       (out_last),
    .scan_busy      (scan_busy),
    .scan_done      (scan_done),
    .frame_overrun  (frame_overrun)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Header store: synchronous write, one-cycle registered read of all eight
  // registers of the addressed layer.
  always @(posedge clk) begin
    if (store_clear) begin
      for (int l = 0; l < 32; l++)
        for (int r = 0; r < 8; r++)
          store[l][r] <= 16'h0000;
    end else if (hdr_write_en) begin
      store[hdr_write_layer][hdr_write_reg] <= hdr_write_data;
    end
    for (int r = 0; r < 8; r++)
      hdr_layer_info[16*r +: 16] <= store[hdr_read_layer][r];
  end

  // Expected header for a layer, assembled from the shadow copy.
  function automatic logic [127:0] exp_info(input int l);
    logic [127:0] v;
    for (int r = 0; r < 8; r++)
      v[16*r +: 16] = shadow[l][r];
    return v;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    compares++;
    if (actual !== expected) begin
      mismatches++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Host register write; waits (bounded) for ready and records it in the shadow.
  task automatic hostWrite(input logic [4:0] l, input logic [2:0] r, input logic [15:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    host_wr_valid = 1'b1;
    host_wr_layer = l;
    host_wr_reg   = r;
    host_wr_data  = d;
    #1;
    while (!host_wr_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!host_wr_ready) checkOutput("wr_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    host_wr_valid = 1'b0;
    shadow[l][r] = d;
  endtask

  // Pulse frame_start for exactly one clock edge; returns at the negedge after it.
  task automatic applyStimulus();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Full scan with out_ready held high. Expects descriptors 0, 5, 31 in order,
  // out_last only on 31, one scan_done one cycle after the last handshake.
  // When overrun_at >= 0 a stray frame_start is injected at that cycle.
  task automatic runScan(input string tag, input int overrun_at);
    int n_desc, n_done, hs_last, done_cyc;
    logic [4:0] seen [3];
    logic [4:0] want [3];
    want[0] = 5'd0; want[1] = 5'd5; want[2] = 5'd31;
    n_desc = 0; n_done = 0; hs_last = -100; done_cyc = -200;
    for (int i = 0; i < 3; i++) seen[i] = 5'h1f;
    out_ready = 1'b1;
    applyStimulus();
    for (int c = 0; c < 120; c++) begin
      #1;
      if (out_valid && out_ready) begin
        if (n_desc < 3) seen[n_desc] = out_layer;
        checkOutput({tag, "_info"}, out_info, exp_info(int'(out_layer)));
        checkOutput({tag, "_last"}, 128'(out_last), 128'(out_layer == 5'd31));
        if (out_layer == 5'd31) hs_last = c;
        n_desc++;
      end
      if (scan_done) begin
        n_done++;
        done_cyc = c;
      end
      if (c == overrun_at) frame_start = 1'b1;
      if (overrun_at >= 0 && c == overrun_at + 1) begin
        frame_start = 1'b0;
        checkOutput({tag, "_overrun_pulse"}, 128'(frame_overrun), 128'd1);
      end
      if (overrun_at >= 0 && c == overrun_at + 2)
        checkOutput({tag, "_overrun_clear"}, 128'(frame_overrun), 128'd0);
      @(negedge clk);
    end
    checkOutput({tag, "_desc_count"}, 128'(n_desc), 128'd3);
    for (int i = 0; i < 3; i++)
      checkOutput({tag, "_order"}, 128'(seen[i]), 128'(want[i]));
    checkOutput({tag, "_done_count"}, 128'(n_done), 128'd1);
    checkOutput({tag, "_done_timing"}, 128'(done_cyc - hs_last), 128'd1);
  endtask

  initial begin
    int waited;
    logic [127:0] held_info;

    reset = 1'b1; store_clear = 1'b1; frame_start = 1'b0;
    host_wr_valid = 1'b0; host_wr_layer = '0; host_wr_reg = '0; host_wr_data = '0;
    out_ready = 1'b0;
    for (int l = 0; l < 32; l++)
      for (int r = 0; r < 8; r++)
        shadow[l][r] = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_scan_busy", 128'(scan_busy), 128'd0);
    checkOutput("rst_wr_ready", 128'(host_wr_ready), 128'd1);
    checkOutput("rst_read_layer", 128'(hdr_read_layer), 128'd0);
    checkOutput("rst_out_info", out_info, 128'd0);
    checkOutput("rst_scan_done", 128'(scan_done), 128'd0);
    reset = 1'b0; store_clear = 1'b0;

    // Program headers: layers 0, 5, 31 enabled; layer 7 has only bit 1 set.
    for (int r = 0; r < 8; r++)
      hostWrite(5'd0, 3'(r), (r == 0) ? 16'h0001 : (16'hA000 + 16'(r)));
    hostWrite(5'd5, 3'd0, 16'h0003);
    hostWrite(5'd5, 3'd1, 16'h5511);
    hostWrite(5'd31, 3'd0, 16'h8001);
    hostWrite(5'd31, 3'd7, 16'h3131);
    hostWrite(5'd7, 3'd0, 16'h0002);

    // First-descriptor latency, then a 10-cycle stall on layer 5
    out_ready = 1'b0;
    applyStimulus();
    checkOutput("lat_t1_busy", 128'(scan_busy), 128'd1);
    checkOutput("lat_t1_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    checkOutput("lat_t2_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    checkOutput("lat_t3_valid", 128'(out_valid), 128'd1);
    checkOutput("lat_t3_layer", 128'(out_layer), 128'd0);
    checkOutput("lat_t3_info", out_info, exp_info(0));
    checkOutput("lat_t3_last", 128'(out_last), 128'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("stall_reach", 128'(out_valid), 128'd1);
    checkOutput("stall_layer0", 128'(out_layer), 128'd5);
    held_info = exp_info(5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 128'(out_valid), 128'd1);
      checkOutput("stall_layer", 128'(out_layer), 128'd5);
      checkOutput("stall_info", out_info, held_info);
      checkOutput("stall_cur", 128'(hdr_read_layer), 128'd5);
    end
    out_ready = 1'b1;
    waited = 0;
    while (scan_busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("stall_finish", 128'(scan_busy), 128'd0);

    // Complete scan ordering and last/done behaviour
    runScan("scan", -1);

    // Stalled write to the layer being fetched; write to another layer passes
    out_ready = 1'b0;
    applyStimulus();
    host_wr_valid = 1'b1; host_wr_layer = 5'd0; host_wr_reg = 3'd1; host_wr_data = 16'hBEEF;
    #1;
    checkOutput("wr_issue_ready", 128'(host_wr_ready), 128'd0);
    checkOutput("wr_issue_en", 128'(hdr_write_en), 128'd0);
    @(negedge clk);
    #1;
    checkOutput("wr_wait_ready", 128'(host_wr_ready), 128'd0);
    checkOutput("wr_wait_en", 128'(hdr_write_en), 128'd0);
    @(negedge clk);
    #1;
    checkOutput("wr_emit_ready", 128'(host_wr_ready), 128'd1);
    checkOutput("wr_emit_en", 128'(hdr_write_en), 128'd1);
    checkOutput("wr_prewrite_info", out_info, exp_info(0));
    out_ready = 1'b1;
    @(negedge clk);
    shadow[0][1] = 16'hBEEF;
    host_wr_layer = 5'd7; host_wr_reg = 3'd2; host_wr_data = 16'h7777;
    #1;
    checkOutput("wr_other_cur", 128'(hdr_read_layer), 128'd1);
    checkOutput("wr_other_ready", 128'(host_wr_ready), 128'd1);
    checkOutput("wr_other_en", 128'(hdr_write_en), 128'd1);
    checkOutput("wr_other_layer", 128'(hdr_write_layer), 128'd7);
    @(negedge clk);
    host_wr_valid = 1'b0;
    shadow[7][2] = 16'h7777;
    waited = 0;
    while (scan_busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("wr_finish", 128'(scan_busy), 128'd0);

    // Stray frame_start mid-scan
    runScan("ovr", 20);

    // Reset while a descriptor is held in EMIT, then restart
    out_ready = 1'b0;
    applyStimulus();
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("rst_emit_reach", 128'(out_valid), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_emit_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_emit_busy", 128'(scan_busy), 128'd0);
    checkOutput("rst_emit_done", 128'(scan_done), 128'd0);
    checkOutput("rst_emit_info", out_info, 128'd0);
    checkOutput("rst_emit_cur", 128'(hdr_read_layer), 128'd0);
    reset = 1'b0;
    runScan("restart", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
